// File: rtl/mem_arb_pkg.sv
// Shared types, widths and helpers for the memory-port round-robin arbiter.
package mem_arb_pkg;

  localparam int unsigned MEM_ARB_CNT_W = 8;
  localparam int unsigned MEM_ARB_IDX_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } mem_arb_state_e;

  // Pending read return: which requester gets the data the cycle after next.
  typedef struct packed {
    logic                     vld;
    logic [MEM_ARB_IDX_W-1:0] idx;
  } mem_arb_ret_t;

  // Increment modulo n, used for the round-robin pointer.
  function automatic int unsigned mem_arb_inc_mod(input int unsigned x, input int unsigned n);
    return (x + 1 >= n) ? 0 : x + 1;
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Requester-side handshake and memory-side command/response signals of the arbiter.
interface mem_arb_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 10,
  parameter int unsigned DW   = 32
);
  logic [NREQ-1:0]    mem_arb_req_ip;
  logic [NREQ-1:0]    mem_arb_lock_ip;
  logic [NREQ-1:0]    mem_arb_we_ip;
  logic [NREQ*AW-1:0] mem_arb_addr_ip;
  logic [NREQ*DW-1:0] mem_arb_wdata_ip;
  logic [NREQ-1:0]    mem_arb_gnt_op;
  logic [NREQ-1:0]    mem_arb_rvalid_op;
  logic [DW-1:0]      mem_arb_rdata_op;
  logic               mem_arb_en_op;
  logic               mem_arb_mwe_op;
  logic [AW-1:0]      mem_arb_maddr_op;
  logic [DW-1:0]      mem_arb_mwdata_op;
  logic [DW-1:0]      mem_arb_mrdata_ip;
  logic               mem_arb_busy_op;

  modport slave (
    input  mem_arb_req_ip, mem_arb_lock_ip, mem_arb_we_ip, mem_arb_addr_ip,
           mem_arb_wdata_ip, mem_arb_mrdata_ip,
    output mem_arb_gnt_op, mem_arb_rvalid_op, mem_arb_rdata_op, mem_arb_en_op,
           mem_arb_mwe_op, mem_arb_maddr_op, mem_arb_mwdata_op, mem_arb_busy_op
  );

  modport master (
    output mem_arb_req_ip, mem_arb_lock_ip, mem_arb_we_ip, mem_arb_addr_ip,
           mem_arb_wdata_ip, mem_arb_mrdata_ip,
    input  mem_arb_gnt_op, mem_arb_rvalid_op, mem_arb_rdata_op, mem_arb_en_op,
           mem_arb_mwe_op, mem_arb_maddr_op, mem_arb_mwdata_op, mem_arb_busy_op
  );

endinterface

// File: rtl/mem_arb_rr_pick.sv
// Combinational round-robin picker: first masked request at or after ptr, wrapping.
module mem_arb_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  input  logic [NREQ-1:0] mask_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o,
  output logic            vld_o
);

  logic [NREQ-1:0] req_m;
  logic [PW:0]     pos;

  assign req_m = req_i & mask_i;

  // Scan ptr, ptr+1, ... modulo NREQ and keep the first hit.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    pos   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      pos = {1'b0, ptr_i} + (PW+1)'(i);
      if (pos >= (PW+1)'(NREQ)) pos = pos - (PW+1)'(NREQ);
      if (!vld_o && req_m[pos[PW-1:0]]) begin
        vld_o = 1'b1;
        idx_o = pos[PW-1:0];
      end
    end
    if (vld_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/mem_arb.sv
// Round-robin arbiter with optional locked bursts sharing one synchronous RAM port.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned AW        = 10,
  parameter int unsigned DW        = 32,
  parameter int unsigned BURST_MAX = 8
) (
  input logic      mem_arb_clk_ip,
  input logic      mem_arb_rst_n_ip,
  mem_arb_if.slave bus_if
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  mem_arb_state_e           state_q, state_d;
  logic [PW-1:0]            owner_q, owner_d;
  logic [PW-1:0]            ptr_q, ptr_d;
  logic [MEM_ARB_CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]          mask_c;

  logic [NREQ-1:0] pick_gnt;
  logic [PW-1:0]   pick_idx;
  logic            pick_vld;
  logic            grant_vld;

  logic            sel_we, sel_lock;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            owner_req, owner_lock;

  logic            en_q, mwe_q;
  logic [AW-1:0]   maddr_q;
  logic [DW-1:0]   mwdata_q;
  mem_arb_ret_t    ret_q;
  logic [NREQ-1:0] rvalid_q, rvalid_d;

  mem_arb_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req_i  (bus_if.mem_arb_req_ip),
    .ptr_i  (ptr_q),
    .mask_i (mask_c),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .vld_o  (pick_vld)
  );

  // No grant is visible while reset is held.
  assign grant_vld = pick_vld & mem_arb_rst_n_ip;

  // Select the granted requester's command and the owner's handshake bits.
  always_comb begin
    sel_we     = 1'b0;
    sel_lock   = 1'b0;
    sel_addr   = '0;
    sel_wdata  = '0;
    owner_req  = 1'b0;
    owner_lock = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_idx == PW'(i)) begin
        sel_we    = bus_if.mem_arb_we_ip[i];
        sel_lock  = bus_if.mem_arb_lock_ip[i];
        sel_addr  = bus_if.mem_arb_addr_ip[i*AW +: AW];
        sel_wdata = bus_if.mem_arb_wdata_ip[i*DW +: DW];
      end
      if (owner_q == PW'(i)) begin
        owner_req  = bus_if.mem_arb_req_ip[i];
        owner_lock = bus_if.mem_arb_lock_ip[i];
      end
    end
  end

  // FSM state, owner, burst count and round-robin pointer registers.
  always_ff @(posedge mem_arb_clk_ip or negedge mem_arb_rst_n_ip) begin
    if (!mem_arb_rst_n_ip) begin
      state_q <= IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: enter OWN on a locked grant, leave on unlock, idle owner or burst limit.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (grant_vld) ptr_d = PW'(mem_arb_inc_mod(32'(pick_idx), NREQ));
    unique case (state_q)
      IDLE: begin
        if (grant_vld && sel_lock && (BURST_MAX > 1)) begin
          state_d = OWN;
          owner_d = pick_idx;
          cnt_d   = MEM_ARB_CNT_W'(1);
        end
      end
      OWN: begin
        if (!owner_req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (grant_vld) begin
          cnt_d = cnt_q + MEM_ARB_CNT_W'(1);
          if (!owner_lock || (cnt_d == MEM_ARB_CNT_W'(BURST_MAX))) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: restrict arbitration to the owner during a burst.
  always_comb begin
    mask_c = '1;
    if (state_q == OWN) begin
      mask_c          = '0;
      mask_c[owner_q] = 1'b1;
    end
  end

  // Command register toward the RAM, loaded on each grant.
  always_ff @(posedge mem_arb_clk_ip or negedge mem_arb_rst_n_ip) begin
    if (!mem_arb_rst_n_ip) begin
      en_q     <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      en_q  <= grant_vld;
      mwe_q <= grant_vld & sel_we;
      if (grant_vld) begin
        maddr_q  <= sel_addr;
        mwdata_q <= sel_wdata;
      end
    end
  end

  // One-hot read valid decoded from the pending return slot.
  always_comb begin
    rvalid_d = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rvalid_d[i] = ret_q.vld && (ret_q.idx == MEM_ARB_IDX_W'(i));
    end
  end

  // Read-return pipeline: grant -> pending slot -> rvalid aligned with RAM data.
  always_ff @(posedge mem_arb_clk_ip or negedge mem_arb_rst_n_ip) begin
    if (!mem_arb_rst_n_ip) begin
      ret_q    <= '0;
      rvalid_q <= '0;
    end else begin
      ret_q.vld <= grant_vld & ~sel_we;
      ret_q.idx <= MEM_ARB_IDX_W'(pick_idx);
      rvalid_q  <= rvalid_d;
    end
  end

  assign bus_if.mem_arb_gnt_op    = pick_gnt & {NREQ{mem_arb_rst_n_ip}};
  assign bus_if.mem_arb_rvalid_op = rvalid_q;
  assign bus_if.mem_arb_rdata_op  = (|rvalid_q) ? bus_if.mem_arb_mrdata_ip : '0;
  assign bus_if.mem_arb_en_op     = en_q;
  assign bus_if.mem_arb_mwe_op    = mwe_q;
  assign bus_if.mem_arb_maddr_op  = maddr_q;
  assign bus_if.mem_arb_mwdata_op = mwdata_q;
  assign bus_if.mem_arb_busy_op   = (state_q == OWN);

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level reference model.
module tb_mem_arb;

  localparam int NREQ = 4;
  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int BM   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arb_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  mem_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .BURST_MAX(BM)) dut (
    .mem_arb_clk_ip   (clk),
    .mem_arb_rst_n_ip (rst_n),
    .bus_if           (bus)
  );

  // Requester drive state
  logic [NREQ-1:0] req = '0, lock = '0, we = '0;
  logic [AW-1:0]   addr [NREQ];
  logic [DW-1:0]   wd   [NREQ];

  assign bus.mem_arb_req_ip  = req;
  assign bus.mem_arb_lock_ip = lock;
  assign bus.mem_arb_we_ip   = we;
  always_comb begin
    logic [NREQ*AW-1:0] a;
    logic [NREQ*DW-1:0] d;
    a = '0;
    d = '0;
    for (int i = 0; i < NREQ; i++) begin
      a[i*AW +: AW] = addr[i];
      d[i*DW +: DW] = wd[i];
    end
    bus.mem_arb_addr_ip  = a;
    bus.mem_arb_wdata_ip = d;
  end

  // Synchronous RAM behind the arbiter
  logic [DW-1:0] ram [0:1023];
  logic [DW-1:0] ram_q = '0;
  always @(posedge clk) begin
    if (bus.mem_arb_en_op) begin
      if (bus.mem_arb_mwe_op) ram[bus.mem_arb_maddr_op] <= bus.mem_arb_mwdata_op;
      else                    ram_q <= ram[bus.mem_arb_maddr_op];
    end
  end
  assign bus.mem_arb_mrdata_ip = ram_q;

  logic [NREQ-1:0] gnt, rvalid;
  assign gnt    = bus.mem_arb_gnt_op;
  assign rvalid = bus.mem_arb_rvalid_op;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    else n_pass++;
  endtask

  // Reference model: arbitration rules, shadow memory, expected pipelines
  logic [DW-1:0] shadow [0:1023];
  bit  mon_en = 1'b0;
  bit  m_own;
  int  m_ptr, m_owner, m_cnt;
  bit  c_v, c_we;
  int  c_idx;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wd, c_rd;
  bit  r_v;
  int  r_idx;
  logic [DW-1:0] r_data;
  logic [NREQ-1:0] gnt_seen = '0;

  task automatic model_reset();
    m_own = 0; m_ptr = 0; m_owner = 0; m_cnt = 0;
    c_v = 0; c_we = 0; c_idx = 0; r_v = 0; r_idx = 0;
  endtask

  always @(negedge clk) begin : monitor
    int g;
    gnt_seen = gnt;
    if (mon_en) begin
      chk("en", 32'(bus.mem_arb_en_op), 32'(c_v));
      if (c_v) begin
        chk("mwe", 32'(bus.mem_arb_mwe_op), 32'(c_we));
        chk("maddr", 32'(bus.mem_arb_maddr_op), 32'(c_addr));
        if (c_we) chk("mwdata", bus.mem_arb_mwdata_op, c_wd);
      end
      chk("rvalid", 32'(rvalid), r_v ? (32'd1 << r_idx) : 32'd0);
      if (r_v) chk("rdata", bus.mem_arb_rdata_op, r_data);
      chk("busy", 32'(bus.mem_arb_busy_op), 32'(m_own));
      g = -1;
      if (m_own) begin
        if (req[m_owner]) g = m_owner;
      end else begin
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && req[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      end
      chk("gnt", 32'(gnt), (g >= 0) ? (32'd1 << g) : 32'd0);
      r_v = c_v && !c_we; r_idx = c_idx; r_data = c_rd;
      c_v = (g >= 0);
      if (g >= 0) begin
        c_idx = g; c_we = we[g]; c_addr = addr[g]; c_wd = wd[g];
        if (we[g]) shadow[addr[g]] = wd[g];
        else       c_rd = shadow[addr[g]];
        m_ptr = (g + 1) % NREQ;
      end
      if (m_own) begin
        if (!req[m_owner]) m_own = 0;
        else begin
          m_cnt++;
          if (!lock[m_owner] || m_cnt == BM) m_own = 0;
        end
      end else if (g >= 0 && lock[g] && BM > 1) begin
        m_own = 1; m_owner = g; m_cnt = 1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit l);
    req[i] = 1'b1; we[i] = w; addr[i] = a; wd[i] = d; lock[i] = l;
  endtask

  task automatic drop_all();
    req = '0; lock = '0; we = '0;
  endtask

  task automatic do_reset();
    cyc();
    mon_en = 0;
    rst_n  = 1'b0;
    drop_all();
    cyc(); cyc();
    rst_n = 1'b1;
    model_reset();
    mon_en = 1;
  endtask

  task automatic wait_gnt(input int i);
    bit found;
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (gnt[i]) found = 1;
    end
    if (!found) chk("wait_gnt", 32'd0, 32'd1);
  endtask

  task automatic new_cmd(input int i);
    req[i]  = 1'b1;
    we[i]   = 1'($urandom_range(1));
    addr[i] = AW'($urandom_range(15));
    wd[i]   = $urandom;
    lock[i] = lock[i] ? ($urandom_range(99) < 90) : ($urandom_range(99) < 25);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]    = $urandom;
      shadow[i] = ram[i];
    end
    for (int i = 0; i < NREQ; i++) begin
      addr[i] = '0;
      wd[i]   = '0;
    end
    model_reset();

    // Reset state
    #12;
    req = '1;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_en", 32'(bus.mem_arb_en_op), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_busy", 32'(bus.mem_arb_busy_op), 32'd0);
    chk("rst_maddr", 32'(bus.mem_arb_maddr_op), 32'd0);
    req = '0;
    cyc();
    rst_n  = 1'b1;
    mon_en = 1;

    // 1: all reading, unlocked -> 0,1,2,3,0
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(16 + i), '0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t1_gnt", 32'(gnt), 32'd1 << (k % NREQ));
      cyc();
    end
    drop_all();
    cyc(); cyc(); cyc();

    // 2: write 0x3FF from req1, read it back from req2
    set_req(1, 1'b1, 10'h3FF, 32'hDEADBEEF, 1'b0);
    wait_gnt(1);
    cyc();
    drop_all();
    @(negedge clk);
    chk("t2_en", 32'(bus.mem_arb_en_op), 32'd1);
    chk("t2_mwe", 32'(bus.mem_arb_mwe_op), 32'd1);
    chk("t2_maddr", 32'(bus.mem_arb_maddr_op), 32'h3FF);
    chk("t2_mwdata", bus.mem_arb_mwdata_op, 32'hDEADBEEF);
    cyc();
    set_req(2, 1'b0, 10'h3FF, '0, 1'b0);
    wait_gnt(2);
    cyc();
    drop_all();
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("t2_rvalid", 32'(rvalid), 32'd4);
    chk("t2_rdata", bus.mem_arb_rdata_op, 32'hDEADBEEF);

    // 3: locked burst from req0 with req3 waiting -> 8 grants then req3
    do_reset();
    set_req(0, 1'b0, 10'd1, '0, 1'b1);
    set_req(3, 1'b0, 10'd2, '0, 1'b0);
    for (int k = 0; k < BM; k++) begin
      @(negedge clk);
      chk("t3_gnt", 32'(gnt), 32'd1);
      chk("t3_busy", 32'(bus.mem_arb_busy_op), 32'(k > 0));
      cyc();
    end
    @(negedge clk);
    chk("t3_next", 32'(gnt), 32'd8);
    chk("t3_busy_end", 32'(bus.mem_arb_busy_op), 32'd0);
    cyc();
    drop_all();
    cyc();

    // 4: req2 locks, drops after 3 beats, waiting req0 follows
    do_reset();
    set_req(2, 1'b0, 10'd3, '0, 1'b1);
    @(negedge clk);
    chk("t4_first", 32'(gnt), 32'd4);
    cyc();
    set_req(0, 1'b0, 10'd4, '0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t4_beat", 32'(gnt), 32'd4);
      cyc();
    end
    req[2] = 1'b0;
    @(negedge clk);
    chk("t4_drop", 32'(gnt), 32'd0);
    chk("t4_busy", 32'(bus.mem_arb_busy_op), 32'd1);
    cyc();
    @(negedge clk);
    chk("t4_after", 32'(gnt), 32'd1);
    cyc();
    drop_all();
    cyc();

    // 5: reset one cycle after a read grant
    do_reset();
    set_req(0, 1'b0, 10'd5, '0, 1'b0);
    @(negedge clk);
    chk("t5_gnt", 32'(gnt), 32'd1);
    cyc();
    drop_all();
    #1;
    mon_en = 0;
    rst_n  = 1'b0;
    req    = '1;
    #1;
    chk("t5_en", 32'(bus.mem_arb_en_op), 32'd0);
    chk("t5_gnt_rst", 32'(gnt), 32'd0);
    chk("t5_rvalid", 32'(rvalid), 32'd0);
    chk("t5_maddr", 32'(bus.mem_arb_maddr_op), 32'd0);
    cyc(); cyc();
    req    = '0;
    rst_n  = 1'b1;
    model_reset();
    mon_en = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_no_rvalid", 32'(rvalid), 32'd0);
      cyc();
    end
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(i), '0, 1'b0);
    @(negedge clk);
    chk("t5_ptr0", 32'(gnt), 32'd1);
    cyc();
    drop_all();
    cyc();

    // 6: pointer wrap 3 -> 0
    do_reset();
    set_req(2, 1'b0, 10'd6, '0, 1'b0);
    @(negedge clk);
    chk("t6_g2", 32'(gnt), 32'd4);
    cyc();
    req[2] = 1'b0;
    set_req(3, 1'b0, 10'd7, '0, 1'b0);
    @(negedge clk);
    chk("t6_g3", 32'(gnt), 32'd8);
    cyc();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(8 + i), '0, 1'b0);
    @(negedge clk);
    chk("t6_wrap", 32'(gnt), 32'd1);
    cyc();
    drop_all();
    cyc();

    // Random traffic checked cycle by cycle by the model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          if (gnt_seen[i]) begin
            if ($urandom_range(99) < 70) new_cmd(i);
            else begin
              req[i]  = 1'b0;
              lock[i] = 1'b0;
            end
          end
        end else if ($urandom_range(99) < 35) begin
          new_cmd(i);
        end
      end
      cyc();
    end
    drop_all();
    cyc(); cyc(); cyc(); cyc();
    mon_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
